// File: rtl/random_bcd_gen_pkg.sv
// random_bcd_pkg: shared types and constants for the random BCD generator.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: state enum, BCD_MAX, default right-shift Galois tap masks, is_bcd().
package random_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Maximal-length feedback masks for a right-shifting Galois LFSR.
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   function automatic logic is_bcd(input logic [3:0] nib);
      return nib <= BCD_MAX;
   endfunction

endpackage

// File: rtl/random_bcd_gen_if.sv
// random_bcd_gen_if: control/result bundle between the game FSM and the generator.
// Latency: n/a (wires only).
// Backpressure: none; start is a request pulse, valid is a level held until the next draw.
// master = game FSM side (drives start/seed), slave = generator side (drives results).
interface random_bcd_gen_if #(
   parameter int NDIG   = 2,
   parameter int LFSR_W = 16
);
   logic                start;
   logic                seed_load;
   logic [LFSR_W-1:0]   seed;
   logic                busy;
   logic                valid;
   logic [4*NDIG-1:0]   digits;
   logic                neg;
   logic [7:0]          fallbacks;

   modport master (
      output start, seed_load, seed,
      input  busy, valid, digits, neg, fallbacks
   );

   modport slave (
      input  start, seed_load, seed,
      output busy, valid, digits, neg, fallbacks
   );
endinterface

// File: rtl/random_bcd_gen_lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with synchronous load and zero-seed guard.
// Latency: one clock per step; load and advance take effect on the next rising edge.
// Backpressure: none; load has priority over en.
// Ports: Clock, Resetn (async, active low), en (advance), load/load_val (seed), q (state).
module lfsr_galois #(
   parameter int             W    = 16,
   parameter logic [W-1:0]   TAPS = 16'hB400,
   parameter logic [W-1:0]   INIT = 16'h0001
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          en,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   output logic [W-1:0]  q
);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q <= INIT;
      end else if (load) begin
         // An all-zero state would lock the LFSR, so a zero seed becomes 1.
         q <= (load_val == '0) ? W'(1) : load_val;
      end else if (en) begin
         q <= (q >> 1) ^ (q[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/random_bcd_gen.sv
// random_bcd_gen: N-digit random BCD number generator for the guess-the-number game.
// Latency: NDIG+1 clocks from the start edge to valid at best (NDIG+2 with the sign draw),
//          bounded by NDIG*MAX_TRIES(+1) through the per-digit fallback.
// Backpressure: none; start is ignored while busy, valid/digits hold until the next start.
// Ports: Clock, Resetn (async, active low), bus (random_bcd_gen_if.slave).
// Option: define RANDOM_BCD_SIGN_EN to draw a sign bit after the last digit.
module random_bcd_gen
   import random_bcd_pkg::*;
#(
   parameter int                 NDIG      = 2,
   parameter int                 LFSR_W    = 16,
   parameter logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400,
   parameter logic [LFSR_W-1:0]  LFSR_INIT = 16'h0001,
   parameter int                 MAX_TRIES = 32
) (
   input  logic                   Clock,
   input  logic                   Resetn,
   random_bcd_gen_if.slave        bus
);

`ifdef RANDOM_BCD_SIGN_EN
   localparam bit SIGN_EN = 1'b1;
`else
   localparam bit SIGN_EN = 1'b0;
`endif

   localparam int IDX_W = 4;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [TRY_W-1:0]   tries;
   logic [4*NDIG-1:0]  digits_q;
   logic [7:0]         fb_q;
   logic [LFSR_W-1:0]  lfsr_q;
   logic [3:0]         nib;
   logic               launch, take, forced, sign_cyc;
   logic [3:0]         new_digit;
   logic               unused_lfsr_bits;

   lfsr_galois #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS),
      .INIT (LFSR_INIT)
   ) u_lfsr (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .en       (state == DRAW),
      .load     (bus.seed_load),
      .load_val (bus.seed),
      .q        (lfsr_q)
   );

   // Candidate is the LFSR top nibble before this cycle's advance.
   assign nib       = lfsr_q[LFSR_W-1 -: 4];
   assign new_digit = forced ? (nib & 4'h7) : nib;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      take      = 1'b0;
      forced    = 1'b0;
      sign_cyc  = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               launch    = 1'b1;
               state_nxt = DRAW;
            end
         end
         DRAW: begin
            // With the sign draw, idx==NDIG marks the extra cycle after the last digit.
            if (SIGN_EN && idx == IDX_W'(NDIG)) begin
               sign_cyc  = 1'b1;
               state_nxt = DONE;
            end else begin
               if (is_bcd(nib)) begin
                  take = 1'b1;
               end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
                  take   = 1'b1;
                  forced = 1'b1;
               end
               if (take && idx == IDX_W'(NDIG - 1) && !SIGN_EN)
                  state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         idx      <= '0;
         tries    <= '0;
         digits_q <= '0;
         fb_q     <= '0;
      end else if (launch) begin
         idx   <= '0;
         tries <= '0;
      end else if (state == DRAW && !sign_cyc) begin
         if (take) begin
            for (int i = 0; i < NDIG; i++)
               if (idx == IDX_W'(i)) digits_q[4*i +: 4] <= new_digit;
            idx   <= idx + 1'b1;
            tries <= '0;
            if (forced && fb_q != 8'hFF) fb_q <= fb_q + 1'b1;
         end else begin
            tries <= tries + 1'b1;
         end
      end
   end

`ifdef RANDOM_BCD_SIGN_EN
   logic neg_q;
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)       neg_q <= 1'b0;
      else if (launch)   neg_q <= 1'b0;
      // A zero result is never reported as negative.
      else if (sign_cyc) neg_q <= lfsr_q[0] & (|digits_q);
   end
   assign bus.neg = neg_q;
   // Middle LFSR bits feed neither a digit nor the sign.
   assign unused_lfsr_bits = ^lfsr_q[LFSR_W-5:1];
`else
   assign bus.neg = 1'b0;
   // Only the top nibble of the LFSR feeds the digits in this build.
   assign unused_lfsr_bits = ^lfsr_q[LFSR_W-5:0];
`endif

   assign bus.busy      = (state == DRAW);
   assign bus.valid     = (state == DONE);
   assign bus.digits    = digits_q;
   assign bus.fallbacks = fb_q;

endmodule

// File: tb/tb_random_bcd_gen.sv
// tb_random_bcd_gen: randomized scoreboard bench for random_bcd_gen (NDIG=2, MAX_TRIES=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_random_bcd_gen;

   localparam int          NDIG = 2;
   localparam int          W    = 16;
   localparam int          MT   = 4;
   localparam logic [15:0] TAPS = 16'hB400;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   random_bcd_gen_if #(.NDIG(NDIG), .LFSR_W(W)) bus ();

   random_bcd_gen #(
      .NDIG      (NDIG),
      .LFSR_W    (W),
      .LFSR_TAPS (TAPS),
      .LFSR_INIT (16'h0001),
      .MAX_TRIES (MT)
   ) dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [7:0] dig;
      bit         ng;
      logic [7:0] fb;
      int         lat;
      int         t0;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          neg_ones = 0;
   int          draws = 0;
   logic [15:0] m_lfsr;
   int          m_fb;
   bit          prev_v = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   // Reference: draw nibbles from the model sequence, one per DRAW cycle.
   function automatic exp_t model_draw();
      exp_t       e;
      logic [3:0] n;
      int         rej;
      bit         got;
      e.dig = '0;
      e.ng  = 1'b0;
      e.lat = 1;
      e.t0  = 0;
      for (int d = 0; d < NDIG; d++) begin
         rej = 0;
         got = 1'b0;
         while (!got) begin
            n      = m_lfsr[15:12];
            m_lfsr = step(m_lfsr);
            e.lat++;
            if (n <= 4'd9) begin
               e.dig[4*d +: 4] = n;
               got = 1'b1;
            end else begin
               rej++;
               if (rej == MT) begin
                  e.dig[4*d +: 4] = n % 4'd8;
                  got = 1'b1;
                  if (m_fb < 255) m_fb++;
               end
            end
         end
      end
`ifdef RANDOM_BCD_SIGN_EN
      e.ng   = m_lfsr[0] && (e.dig != 8'h00);
      m_lfsr = step(m_lfsr);
      e.lat++;
`endif
      e.fb = 8'(m_fb);
      return e;
   endfunction

   // mode 0: reject, reject, accept.  mode 1: first nib 12 then MT rejects in a row.
   function automatic logic [15:0] find_seed(input int mode);
      logic [15:0] a;
      logic [3:0]  n [4];
      for (int s = 1; s < 65536; s++) begin
         a = 16'(s);
         for (int k = 0; k < 4; k++) begin
            n[k] = a[15:12];
            a    = step(a);
         end
         if (mode == 0 && n[0] > 9 && n[1] > 9 && n[2] <= 9) return 16'(s);
         if (mode == 1 && n[0] == 12 && n[1] > 9 && n[2] > 9 && n[3] > 9) return 16'(s);
      end
      return 16'h0001;
   endfunction

   // Monitor: each rising valid is one completed draw; compare against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      bit   bcd_ok;
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (bus.valid && !prev_v) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
               e = sb.pop_front();
               check("digits", bus.digits, e.dig);
               check("neg", bus.neg, e.ng);
               check("fallbacks", bus.fallbacks, e.fb);
               check("latency", cyc - e.t0, e.lat);
               bcd_ok = 1'b1;
               for (int d = 0; d < NDIG; d++)
                  if (bus.digits[4*d +: 4] > 4'd9) bcd_ok = 1'b0;
               check("bcd_range", bcd_ok, 1);
               neg_ones += int'(bus.neg);
               draws++;
            end
         end
         prev_v = bus.valid;
      end
   end

   task automatic seed_it(input logic [15:0] s);
      bus.seed_load = 1'b1;
      bus.seed      = s;
      @(posedge clk);
      @(negedge clk);
      bus.seed_load = 1'b0;
      m_lfsr = (s == 16'h0) ? 16'h0001 : s;
   endtask

   task automatic draw(input bit poke);
      exp_t e;
      e    = model_draw();
      e.t0 = cyc;
      sb.push_back(e);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("valid_drop", bus.valid, 0);
      check("busy_set", bus.busy, 1);
      if (poke) begin
         // start while busy must be ignored
         bus.start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
      end
      for (int i = 0; i < 200 && !bus.valid; i++) @(negedge clk);
      if (!bus.valid) begin
         check("draw_timeout", 0, 1);
         sb.delete();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [15:0] s;
      int          fbb;
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      bus.seed      = '0;
      m_lfsr        = 16'h0001;
      m_fb          = 0;

      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_digits", bus.digits, 0);
      check("rst_neg", bus.neg, 0);
      check("rst_fallbacks", bus.fallbacks, 0);
      rst_n = 1'b1;
      @(negedge clk);

      draw(0);

      // Reset in the middle of a draw.
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_valid", bus.valid, 0);
      check("midrst_digits", bus.digits, 0);
      check("midrst_fallbacks", bus.fallbacks, 0);
      sb.delete();
      m_lfsr = 16'h0001;
      m_fb   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      draw(0);

      // Seed 0x9000: candidates 9 then 4, both accepted.
      seed_it(16'h9000);
      draw(0);
      check("seed9000_digits", bus.digits, 8'h49);

      // Two rejects then an accept: no fallback.
      s = find_seed(0);
      seed_it(s);
      fbb = m_fb;
      draw(0);
      check("rejects_fb_same", bus.fallbacks, fbb);

      // MAX_TRIES rejects in a row: forced digit and one fallback.
      s = find_seed(1);
      seed_it(s);
      fbb = m_fb;
      draw(0);
      check("fallback_inc", bus.fallbacks, fbb + 1);

      // Zero seed behaves as seed 1; start pulse while busy ignored.
      seed_it(16'h0000);
      draw(1);

      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 3) == 0) seed_it(16'($urandom));
         draw(1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

`ifdef RANDOM_BCD_SIGN_EN
      check("neg_ratio_ok", (neg_ones * 100 >= draws * 45) && (neg_ones * 100 <= draws * 55), 1);
`else
      check("neg_never_set", neg_ones, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
